// File: rtl/iref_pwr_seq_if.sv
// Signal bundle between the current-reference power sequencer and its
// surroundings (EN request, reference ready flag, power/cal controls, status).
interface iref_pwr_seq_if;
    logic       EN;
    logic       RDY_IREF;
    logic       PU_IREF;
    logic       CAL_IREF;
    logic       PU_BIAS;
    logic       READY;
    logic       ERR;
    logic [2:0] STATE;

    // Sequencer side: consumes the request and ready flag, drives controls/status.
    modport master (
        input  EN,
        input  RDY_IREF,
        output PU_IREF,
        output CAL_IREF,
        output PU_BIAS,
        output READY,
        output ERR,
        output STATE
    );

    // Environment side: the requester plus the current-reference block.
    modport slave (
        output EN,
        output RDY_IREF,
        input  PU_IREF,
        input  CAL_IREF,
        input  PU_BIAS,
        input  READY,
        input  ERR,
        input  STATE
    );
endinterface

// File: rtl/iref_pwr_seq.sv
// Power-up sequencer for the current-reference block and the bias stage behind it.
// Brings up the reference, enables calibration until it reports ready, then
// powers the bias stage and reports READY; faults land in a sticky ERR state.
// Optional calibration retry is built when IREF_PWR_SEQ_RETRY_EN is defined.
// T_PU, T_CAL_TO and T_BIAS must lie in 1..255 (a dwell of 0 is illegal).
module iref_pwr_seq #(
    parameter int T_PU     = 5,
    parameter int T_CAL_TO = 50,
    parameter int T_BIAS   = 10
`ifdef IREF_PWR_SEQ_RETRY_EN
    ,
    parameter int MAX_RETRY = 2
`endif
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    iref_pwr_seq_if.master        bus
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_PU    = 3'd1,
        S_CAL   = 3'd2,
        S_BIAS  = 3'd3,
        S_ON    = 3'd4,
        S_ERR   = 3'd5,
        S_PDN   = 3'd6
`ifdef IREF_PWR_SEQ_RETRY_EN
        ,
        S_RETRY = 3'd7
`endif
    } state_t;

    localparam logic [7:0] LD_PU  = 8'(T_PU - 1);
    localparam logic [7:0] LD_CAL = 8'(T_CAL_TO - 1);
    localparam logic [7:0] LD_BIAS = 8'(T_BIAS - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pu_iref_q, pu_iref_d;
    logic       cal_iref_q, cal_iref_d;
    logic       pu_bias_q, pu_bias_d;
    logic       ready_q, ready_d;
    logic       err_q, err_d;
`ifdef IREF_PWR_SEQ_RETRY_EN
    logic [1:0] retry_q, retry_d;
`endif

    // Next state, dwell counter and output decode of the state being entered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
`ifdef IREF_PWR_SEQ_RETRY_EN
        retry_d    = retry_q;
`endif
        pu_iref_d  = 1'b0;
        cal_iref_d = 1'b0;
        pu_bias_d  = 1'b0;
        ready_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_OFF: begin
                if (bus.EN) begin
                    state_d = S_PU;
                    cnt_d   = LD_PU;
                end
            end
            S_PU: begin
                if (!bus.EN) begin
                    state_d = S_PDN;
                end else if (cnt_q == 8'd0) begin
                    state_d = S_CAL;
                    cnt_d   = LD_CAL;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_CAL: begin
                if (!bus.EN) begin
                    state_d = S_PDN;
                end else if (bus.RDY_IREF) begin
                    state_d = S_BIAS;
                    cnt_d   = LD_BIAS;
                end else if (cnt_q == 8'd0) begin
`ifdef IREF_PWR_SEQ_RETRY_EN
                    if (retry_q < 2'(MAX_RETRY)) begin
                        state_d = S_RETRY;
                        retry_d = retry_q + 2'd1;
                    end else begin
                        state_d = S_ERR;
                    end
`else
                    state_d = S_ERR;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_BIAS: begin
                if (!bus.EN) begin
                    state_d = S_PDN;
                end else if (!bus.RDY_IREF) begin
                    state_d = S_ERR;
                end else if (cnt_q == 8'd0) begin
                    state_d = S_ON;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ON: begin
                if (!bus.EN) begin
                    state_d = S_PDN;
                end else if (!bus.RDY_IREF) begin
                    state_d = S_ERR;
                end
            end
            S_PDN: begin
                state_d = S_OFF;
            end
            S_ERR: begin
                if (!bus.EN) begin
                    state_d = S_OFF;
                end
            end
`ifdef IREF_PWR_SEQ_RETRY_EN
            S_RETRY: begin
                if (!bus.EN) begin
                    state_d = S_OFF;
                end else begin
                    state_d = S_PU;
                    cnt_d   = LD_PU;
                end
            end
`endif
            default: begin
                state_d = S_OFF;
            end
        endcase

`ifdef IREF_PWR_SEQ_RETRY_EN
        if (state_d == S_OFF) begin
            retry_d = 2'd0;
        end
`endif

        case (state_d)
            S_PU:   pu_iref_d = 1'b1;
            S_CAL: begin
                pu_iref_d  = 1'b1;
                cal_iref_d = 1'b1;
            end
            S_BIAS: begin
                pu_iref_d = 1'b1;
                pu_bias_d = 1'b1;
            end
            S_ON: begin
                pu_iref_d = 1'b1;
                pu_bias_d = 1'b1;
                ready_d   = 1'b1;
            end
            S_PDN:  pu_iref_d = 1'b1;
            S_ERR:  err_d     = 1'b1;
            default: ;
        endcase
    end

    // State, counter and registered outputs with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= S_OFF;
            cnt_q      <= 8'd0;
            pu_iref_q  <= 1'b0;
            cal_iref_q <= 1'b0;
            pu_bias_q  <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef IREF_PWR_SEQ_RETRY_EN
            retry_q    <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pu_iref_q  <= pu_iref_d;
            cal_iref_q <= cal_iref_d;
            pu_bias_q  <= pu_bias_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
`ifdef IREF_PWR_SEQ_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign bus.PU_IREF  = pu_iref_q;
    assign bus.CAL_IREF = cal_iref_q;
    assign bus.PU_BIAS  = pu_bias_q;
    assign bus.READY    = ready_q;
    assign bus.ERR      = err_q;
    assign bus.STATE    = state_q;

endmodule

// File: doc/iref_pwr_seq.md
Name: iref_pwr_seq

Overview:
- Power-up sequencer sitting directly upstream of the current-reference block.
- Drives the reference's power-up (PU_IREF) and calibration-enable (CAL_IREF) inputs.
- Consumes its ready flag (RDY_IREF), then powers the downstream bias stage (PU_BIAS) and reports a system-level READY/ERR.
- Runs on the 5 MHz system clock (200 ns/cycle).

Parameters:
- T_PU, 5: PU_IREF settle time before calibration starts, in cycles (1 us).
- T_CAL_TO, 50: max cycles in CAL waiting for RDY_IREF before timeout (must exceed the reference's 35-cycle Tcal+Trdy).
- T_BIAS, 10: PU_BIAS settle time before READY, in cycles.
- MAX_RETRY, 2: calibration retries before ERR (only with the optional feature).

Ports:
- CLK  in  1  system clock, 5 MHz, rising edge.
- RSTN  in  1  synchronous active-low reset.
- EN  in  1  sequence request; 1 = power up, 0 = power down.
- RDY_IREF  in  1  ready flag from the current-reference block.
- PU_IREF  out  1  power-up to the current reference.
- CAL_IREF  out  1  calibration enable to the current reference.
- PU_BIAS  out  1  power-up to the downstream bias stage.
- READY  out  1  sequence complete, references valid.
- ERR  out  1  sequence fault (timeout or loss of RDY_IREF).
- STATE  out  3  current FSM state encoding, for debug.

Behaviour:
- **Clocking and reset:** single clock CLK; reset RSTN is synchronous and active-low.
  - RSTN=0 sampled at a rising edge: state=OFF, all outputs 0, counters 0, retry count 0. EN is ignored during reset.
- **Outputs:** all registered, Moore-style; each is a function of the state just entered.
- **Counter:** one 8-bit down-counter, loaded on each entry to a timed state.
  - A timed state exits on the edge where cnt==0.
  - Dwell equals the loaded parameter value.
- **EN precedence:** EN=0 has priority over every other event in PU, CAL, BIAS and ON.
- **States** (encoding, outputs PU_IREF/CAL_IREF/PU_BIAS/READY/ERR):
  - OFF (0), outputs 0/0/0/0/0.
    - EN=1 -> PU, load cnt=T_PU-1.
  - PU (1), outputs 1/0/0/0/0.
    - cnt==0 -> CAL, load cnt=T_CAL_TO-1.
  - CAL (2), outputs 1/1/0/0/0.
    - RDY_IREF=1 -> BIAS, load cnt=T_BIAS-1.
    - cnt==0 with RDY_IREF=0 -> timeout: ERR, or RETRY with the optional feature.
    - RDY_IREF=1 on the timeout edge: RDY wins, go to BIAS.
  - BIAS (3), outputs 1/0/1/0/0.
    - cnt==0 -> ON.
    - RDY_IREF=0 -> ERR.
  - ON (4), outputs 1/0/1/1/0.
    - Holds while EN=1 and RDY_IREF=1.
    - RDY_IREF=0 -> ERR.
  - PDN (6), outputs 1/0/0/0/0.
    - Exactly 1 cycle, then OFF. Bias drops one cycle before the reference.
  - ERR (5), outputs 0/0/0/0/1.
    - Sticky while EN=1.
    - EN=0 -> OFF directly.
  - RETRY (7), outputs 0/0/0/0/0.
    - Exactly 1 cycle; the reference sees PU_IREF low and reloads its count.
    - Then -> PU, load cnt=T_PU-1.
- **EN drop:** EN=0 in PU/CAL/BIAS/ON -> PDN on that edge.
  - EN=0 in RETRY -> OFF.
  - EN toggling back to 1 while in PDN is ignored until OFF is reached.
- **Parameters:** T_PU, T_CAL_TO, T_BIAS must be in 1..255; a value of 0 is illegal.
- **Retry count:** 2-bit, cleared on entry to OFF.
- **Unused encodings:** next state = OFF.

Optional Feature:
- Macro: IREF_PWR_SEQ_RETRY_EN.
- **Defined:**
  - CAL timeout with retry count < MAX_RETRY -> RETRY, and retry count increments.
  - CAL timeout with retry count == MAX_RETRY -> ERR.
- **Undefined:**
  - RETRY state and retry counter are absent.
  - CAL timeout -> ERR immediately.
  - STATE never reads 7.

Test Plan:
All scenarios use default parameters. The reference model asserts RDY_IREF 35 cycles after CAL_IREF rises (unless overridden) and clears RDY_IREF when PU_IREF=0.
1. **Reset:** RSTN=0 for 3 edges with EN=1 -> STATE=0 and all outputs 0 throughout; RSTN=1 at edge R -> PU_IREF=1 after edge R+1.
2. **Nominal power-up:** EN=1 sampled at edge E.
   - PU_IREF=1 after E.
   - CAL_IREF=1 after E+5.
   - RDY_IREF seen at edge N -> CAL_IREF=0 and PU_BIAS=1 after N.
   - READY=1 after N+10; STATE=4.
3. **Calibration timeout (macro undefined):** RDY_IREF forced 0.
   - ERR=1 and PU_IREF=0 exactly 50 cycles after CAL_IREF rose.
   - Stays in ERR with EN=1.
   - EN=0 -> STATE=0 next edge.
4. **Power-down:**
   - EN=0 in ON -> PU_BIAS=0 and READY=0 at the next edge, PU_IREF=0 one edge later, STATE sequence 4,6,0.
   - Repeat with EN=0 mid-CAL -> CAL_IREF=0 immediately, STATE 2,6,0.
5. **Loss of ready:** RDY_IREF pulsed 0 for one cycle in ON -> ERR=1 and READY=0 at the next edge; RDY_IREF returning high does not clear ERR.
6. **Retry (macro defined):** RDY_IREF forced 0.
   - Three CAL windows of 50 cycles each, separated by 1-cycle PU_IREF=0 gaps and 5-cycle PU phases.
   - ERR=1 after the third timeout.
   - Repeat with RDY_IREF released during the second CAL -> READY=1, ERR never asserts.
